// File: rtl/asrv32_uart_loader.sv
// asrv32_uart_loader: UART boot loader for the ASRV32 SoC.
//
// Receives a program image over an 8N1 serial line and writes it into main
// memory one 32-bit word at a time. The core is held in reset while the image
// is loading, and is released once the complete image has arrived.
//
// Frame on the wire:
//   0xA5, LEN_LO, LEN_HI, then 4*N data bytes (each word sent LSB first)
//
// Optional feature macro: ASRV32_LOADER_CHECKSUM_EN
//   When defined, one more byte follows the data. It carries the XOR of all
//   data bytes, and a mismatch sends the loader to the error state.
//   When undefined, the CSUM state does not exist and DONE follows the last
//   write directly.
//
// Handshake note: byte_valid is a one-cycle strobe with no back-pressure.
// The receiver never waits on the loader FSM, and the FSM consumes every
// strobe in the cycle it is raised. Because of this, a memory write never
// stalls reception.

module asrv32_uart_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int MEMORY_DEPTH = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_uart_rx,
  output logic        o_wr_en,
  output logic [3:0]  o_wr_mask,
  output logic [31:0] o_addr,
  output logic [31:0] o_data,
  output logic        o_core_rst_n,
  output logic        o_busy,
  output logic        o_err
);

  localparam int MAX_WORDS = MEMORY_DEPTH / 4;
  // One extra bit, so that the index can hold MAX_WORDS itself after the last increment.
  localparam int KW = $clog2(MAX_WORDS) + 1;
  localparam int CW = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0]   MAX_LEN   = 16'(MAX_WORDS);
  localparam logic [7:0]    SYNC_BYTE = 8'hA5;

  // ---------------------------------------------------------------------------
  // RX front end
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  logic            rx_meta;
  logic            rx_sync;
  logic            rx_prev;
  rx_state_t       rx_state;
  logic [CW-1:0]   rx_cnt;
  logic [2:0]      rx_bit;
  logic [7:0]      rx_shift;
  logic            byte_valid;
  logic            frame_err;

  // Two-flop synchronizer, plus one delayed copy used for falling-edge detection.
  // All three flops idle high, so leaving reset cannot look like a start bit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= i_uart_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Bit-timing engine: re-check at mid start bit, then sample every bit period.
  // rx_shift keeps the received byte stable for many cycles after byte_valid,
  // so the loader FSM can read it directly.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_state   <= RX_IDLE;
      rx_cnt     <= '0;
      rx_bit     <= '0;
      rx_shift   <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_sync) begin
            rx_state <= RX_START;
            rx_cnt   <= '0;
          end
        end
        RX_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt <= '0;
            rx_bit <= '0;
            // If the line is high again here, the low level was a glitch and not a start bit.
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        RX_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_sync, rx_shift[7:1]};
            if (rx_bit == 3'd7) begin
              rx_state <= RX_STOP;
            end else begin
              rx_bit <= rx_bit + 3'd1;
            end
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        RX_STOP: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
            if (rx_sync) begin
              byte_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        default: begin
          rx_state <= RX_IDLE;
          rx_cnt   <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Loader FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_SYNC,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
`ifdef ASRV32_LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE,
    S_ERR
  } state_t;

  state_t          state;
  logic [7:0]      len_lo;
  logic [15:0]     len;
  logic [KW-1:0]   k;
  logic [1:0]      byte_idx;
  logic [23:0]     asm_word;
  logic [15:0]     len_word;
  logic            last_word;
`ifdef ASRV32_LOADER_CHECKSUM_EN
  logic [7:0]      csum;
`endif

  // The full 16-bit length from the two header bytes, and a flag for the final word of the image.
  assign len_word  = {rx_shift, len_lo};
  assign last_word = (16'(k) == (len - 16'd1));

  // Frame parser and memory write port. All outputs are registered here.
  // o_core_rst_n follows DONE with one cycle of delay, so it rises in the cycle after the final write.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= S_SYNC;
      len_lo       <= '0;
      len          <= '0;
      k            <= '0;
      byte_idx     <= '0;
      asm_word     <= '0;
`ifdef ASRV32_LOADER_CHECKSUM_EN
      csum         <= '0;
`endif
      o_wr_en      <= 1'b0;
      o_wr_mask    <= 4'h0;
      o_addr       <= '0;
      o_data       <= '0;
      o_core_rst_n <= 1'b0;
      o_busy       <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      o_wr_en   <= 1'b0;
      o_wr_mask <= 4'h0;
      if (state == S_DONE) begin
        o_core_rst_n <= 1'b1;
      end

      case (state)
        S_SYNC: begin
          // Framing errors are dropped silently while we hunt for the sync byte.
          if (byte_valid && rx_shift == SYNC_BYTE) begin
            state  <= S_LEN_LO;
            o_busy <= 1'b1;
          end
        end

        S_LEN_LO: begin
          if (frame_err) begin
            state  <= S_ERR;
            o_err  <= 1'b1;
            o_busy <= 1'b0;
          end else if (byte_valid) begin
            len_lo <= rx_shift;
            state  <= S_LEN_HI;
          end
        end

        S_LEN_HI: begin
          if (frame_err) begin
            state  <= S_ERR;
            o_err  <= 1'b1;
            o_busy <= 1'b0;
          end else if (byte_valid) begin
            len      <= len_word;
            k        <= '0;
            byte_idx <= '0;
`ifdef ASRV32_LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
            if (len_word == 16'd0) begin
`ifdef ASRV32_LOADER_CHECKSUM_EN
              state  <= S_CSUM;
`else
              state  <= S_DONE;
              o_busy <= 1'b0;
`endif
            end else if (len_word > MAX_LEN) begin
              state  <= S_ERR;
              o_err  <= 1'b1;
              o_busy <= 1'b0;
            end else begin
              state <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (frame_err) begin
            state  <= S_ERR;
            o_err  <= 1'b1;
            o_busy <= 1'b0;
          end else if (byte_valid) begin
            byte_idx <= byte_idx + 2'd1;
`ifdef ASRV32_LOADER_CHECKSUM_EN
            csum     <= csum ^ rx_shift;
`endif
            if (byte_idx == 2'd3) begin
              // The fourth byte completes the word. It goes out together with the three bytes already collected.
              o_wr_en   <= 1'b1;
              o_wr_mask <= 4'hF;
              o_addr    <= 32'({k, 2'b00});
              o_data    <= {rx_shift, asm_word};
              k         <= k + KW'(1);
              if (last_word) begin
`ifdef ASRV32_LOADER_CHECKSUM_EN
                state  <= S_CSUM;
`else
                state  <= S_DONE;
                o_busy <= 1'b0;
`endif
              end
            end else begin
              asm_word <= {rx_shift, asm_word[23:8]};
            end
          end
        end

`ifdef ASRV32_LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (frame_err) begin
            state  <= S_ERR;
            o_err  <= 1'b1;
            o_busy <= 1'b0;
          end else if (byte_valid) begin
            o_busy <= 1'b0;
            if (rx_shift == csum) begin
              state <= S_DONE;
            end else begin
              state <= S_ERR;
              o_err <= 1'b1;
            end
          end
        end
`endif

        S_DONE: begin
          // The loader is finished: only i_rst_n leaves this state.
        end

        S_ERR: begin
          // A new sync byte restarts reception of a frame. The word index k is cleared again in LEN_HI.
          if (byte_valid && rx_shift == SYNC_BYTE) begin
            state  <= S_LEN_LO;
            o_err  <= 1'b0;
            o_busy <= 1'b1;
          end
        end

        default: begin
          state <= S_SYNC;
        end
      endcase
    end
  end

endmodule
